xalu: RTL and testbench
=======================

# xalu

Multiply/divide unit for the E stage of the pipelined MIPS core. It executes MULT/MULTU/DIV/DIVU as multi-cycle operations into private HI/LO registers and serves MFHI/MFLO/MTHI/MTLO. It drives the `XALUOut` value that the E->M pipeline register latches when `AO_Msel` selects it. It exports `busy` so the hazard unit can stall any HI/LO instruction sitting in E.

## Interface
Parameters:
- `MULT_CYC`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYC`, default 10: busy cycles for DIV/DIVU.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately when low.
- `op`  in  4  E-stage HI/LO opcode: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE.
- `D1`  in  32  rs operand (forwarded value).
- `D2`  in  32  rt operand (forwarded value).
- `busy`  out  1  high while a mult/div is in flight.
- `start`  out  1  combinational; high when `op` is 1-4 and `busy` is 0. The hazard unit ORs it with `busy`.
- `XALUOut`  out  32  combinational; HI when `op`=MFHI, LO when `op`=MFLO, else 0.
- `HI`, `LO`  out  32 each  architectural registers, exposed for debug and bench checks.

## Operation
- State: HI, LO, busy, cycle counter (4 bits), pending op kind, latched D1/D2 or a precomputed 64-bit result.
- IDLE -> RUN: rising edge with `start`=1.
  - Latch operands and kind.
  - Set busy=1.
  - Load the counter with MULT_CYC or DIV_CYC.
- RUN: each edge decrements the counter. On the edge where the counter reaches 0:
  - write HI/LO;
  - clear busy;
  - return to IDLE.
- MULT: {HI,LO} = signed(D1) * signed(D2), 64-bit. MULTU: the same, unsigned.
- DIV: LO = quotient truncated toward zero; HI = remainder, taking the sign of the dividend.
- DIV special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient into LO, unsigned remainder into HI.
- Divide by zero (D2=0, DIV or DIVU): the busy sequence runs for the full DIV_CYC; HI/LO are left unchanged at completion.
- MTHI/MTLO with busy=0: HI (or LO) <= D1 on the edge.
- MTHI/MTLO with busy=1: ignored. The hazard unit guarantees this never happens; the block must still not corrupt state.
- Mult/div op with busy=1: ignored. `start` is 0, the running operation continues, and the new op is not queued.
- MFHI/MFLO read the current HI/LO registers. During RUN they return pre-operation values; stalls make this unobservable architecturally.
- Async reset low:
  - HI=0, LO=0, busy=0, counter=0 at once, even mid-operation;
  - any in-flight result is discarded;
  - `start` and `XALUOut` follow `op` combinationally.

## Timing
- Mult/div issue timing: `op`=MULT is presented in cycle t with busy=0.
  - `start`=1 in cycle t.
  - busy=1 in cycles t+1 .. t+MULT_CYC.
  - HI/LO are updated by the edge ending cycle t+MULT_CYC.
  - busy=0 and the new HI/LO are visible from cycle t+MULT_CYC+1.
- Divide timing is the same with DIV_CYC.
- Back-to-back: the earliest next accepted start is cycle t+CYC+1. That edge may latch new operands while the old result is visible.
- MTHI/MTLO: one-edge latency.
- MFHI/MFLO: zero latency. `XALUOut` is combinational from HI/LO and `op` and must settle within the E-stage cycle.
- Reset release: the first edge with `reset` high may accept `start`.

## Test plan
- MULT D1=0xFFFFFFFF, D2=0x00000002:
  - busy high exactly 5 cycles;
  - then HI=0xFFFFFFFF, LO=0xFFFFFFFE;
  - an MFLO in the next cycle gives `XALUOut`=0xFFFFFFFE.
- MULTU D1=0xFFFFFFFF, D2=0x00000002 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- Signed and unsigned divide:
  - DIV 0xFFFFFFF9 (-7) / 2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF;
  - DIVU 7/2 -> LO=3, HI=1;
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero and while-busy rejection:
  - MTHI 0x1234, MTLO 0x5678, then DIV x/0 -> busy 10 cycles, HI=0x1234, LO=0x5678 unchanged;
  - a MULT presented while busy leaves busy timing and result unaffected.
- Reset mid-operation: start DIVU 100/3, pull `reset` low in the 4th busy cycle -> busy=0, HI=LO=0 immediately, with no later HI/LO update. After release, MULT 3*4 gives LO=12, HI=0.
- Back-to-back MULT 2*3 then MULT 5*5 issued at the first non-busy cycle -> LO=6 visible for exactly one cycle, then busy for 5 cycles, then LO=25.

Source files
------------

// File: rtl/xalu.sv
// Multi-cycle multiply/divide unit with private HI/LO for the E stage.
// The 64-bit result is computed at issue and committed when the busy countdown expires.
module xalu #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  output logic        busy,
  output logic        start,
  output logic [31:0] XALUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] res_q, res_d;
  logic        wr_q, wr_d;

  logic        is_mult, is_div;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, dvd, dvs, q_mag, r_mag, q_fin, r_fin;

  assign is_mult = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div  = (op == OP_DIV)  || (op == OP_DIVU);

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{D1[31]}}, D1} * {{32{D2[31]}}, D2};
  assign prod_u = {32'd0, D1} * {32'd0, D2};

  // One unsigned divider shared by both divides; DIV works on magnitudes and
  // fixes signs afterwards, which also yields 0x80000000 for MIN/-1.
  assign a_mag = D1[31] ? -D1 : D1;
  assign b_mag = D2[31] ? -D2 : D2;
  assign dvd   = (op == OP_DIV) ? a_mag : D1;
  assign dvs   = (D2 == 32'd0) ? 32'd1 : ((op == OP_DIV) ? b_mag : D2);
  assign q_mag = dvd / dvs;
  assign r_mag = dvd % dvs;
  assign q_fin = ((op == OP_DIV) && (D1[31] ^ D2[31])) ? -q_mag : q_mag;
  assign r_fin = ((op == OP_DIV) && D1[31]) ? -r_mag : r_mag;

  assign busy  = (state_q == RUN);
  assign start = (is_mult || is_div) && (state_q == IDLE);
  assign HI    = hi_q;
  assign LO    = lo_q;

  always_comb begin
    XALUOut = 32'd0;
    if (op == OP_MFHI)      XALUOut = hi_q;
    else if (op == OP_MFLO) XALUOut = lo_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = is_mult ? MULT_LD : DIV_LD;
          wr_d    = is_mult || (D2 != 32'd0);
          if (op == OP_MULT)       res_d = prod_s;
          else if (op == OP_MULTU) res_d = prod_u;
          else                     res_d = {r_fin, q_fin};
        end else if (op == OP_MTHI) begin
          hi_d = D1;
        end else if (op == OP_MTLO) begin
          lo_d = D1;
        end
      end
      RUN: begin
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          if (wr_q) {hi_d, lo_d} = res_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      res_q   <= 64'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: tb/tb_xalu.sv
// Self-checking bench for xalu: directed test-plan scenarios plus a random
// sequence compared against an arithmetic HI/LO model.
module tb_xalu;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] D1, D2;
  logic        busy, start;
  logic [31:0] XALUOut, HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  xalu #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .op(op), .D1(D1), .D2(D2),
    .busy(busy), .start(start), .XALUOut(XALUOut), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the architectural definition.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      4'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      4'd2: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
      4'd3: if (b != 0) begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
      4'd4: if (b != 0) begin lo = a / b; hi = a % b; end
      4'd7: hi = a;
      4'd8: lo = a;
      default: ;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  // Issues a mult/div at the current negedge and returns the busy cycle count.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic st, output int n);
    op = o; D1 = a; D2 = b;
    #1 st = start;
    model(o, a, b, m_hi, m_lo);
    tick();
    op = 4'd0;
    wait_idle(n);
  endtask

  task automatic test_reset;
    reset = 1'b0; op = 4'd0; D1 = 32'd0; D2 = 32'd0;
    tick(); tick();
    checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++;
      $display("FAIL reset_hilo: HI=%h LO=%h want 0/0", HI, LO); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    op = 4'd1; #1;
    checks++; if (start !== 1'b1) begin errors++;
      $display("FAIL reset_start_comb: got %b want 1", start); end
    op = 4'd0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mult;
    logic st; int n;
    issue(4'd1, 32'hFFFFFFFF, 32'h2, st, n);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL mult_start: got %b want 1", st); end
    checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
    checks++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE || HI !== m_hi || LO !== m_lo) begin errors++;
      $display("FAIL mult_result: HI=%h LO=%h want FFFFFFFF/FFFFFFFE", HI, LO); end
    op = 4'd6; #1;
    checks++; if (XALUOut !== 32'hFFFFFFFE) begin errors++;
      $display("FAIL mflo: got %h want FFFFFFFE", XALUOut); end
    op = 4'd5; #1;
    checks++; if (XALUOut !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL mfhi: got %h want FFFFFFFF", XALUOut); end
    op = 4'd0; tick();
    issue(4'd2, 32'hFFFFFFFF, 32'h2, st, n);
    checks++; if (n != 5 || HI !== 32'h1 || LO !== 32'hFFFFFFFE) begin errors++;
      $display("FAIL multu: n=%0d HI=%h LO=%h want 5 00000001/FFFFFFFE", n, HI, LO); end
  endtask

  task automatic test_div;
    logic st; int n;
    issue(4'd3, 32'hFFFFFFF9, 32'h2, st, n);
    checks++; if (n != 10 || LO !== 32'hFFFFFFFD || HI !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL div_neg: n=%0d HI=%h LO=%h want 10 FFFFFFFF/FFFFFFFD", n, HI, LO); end
    issue(4'd4, 32'd7, 32'd2, st, n);
    checks++; if (n != 10 || LO !== 32'd3 || HI !== 32'd1) begin errors++;
      $display("FAIL divu: n=%0d HI=%h LO=%h want 10 1/3", n, HI, LO); end
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, st, n);
    checks++; if (LO !== 32'h80000000 || HI !== 32'd0) begin errors++;
      $display("FAIL div_min_neg1: HI=%h LO=%h want 0/80000000", HI, LO); end
  endtask

  task automatic test_divzero_busy;
    logic st; int n;
    op = 4'd7; D1 = 32'h1234; tick();
    op = 4'd8; D1 = 32'h5678; tick();
    m_hi = 32'h1234; m_lo = 32'h5678;
    checks++; if (HI !== 32'h1234 || LO !== 32'h5678) begin errors++;
      $display("FAIL mthi_mtlo: HI=%h LO=%h want 1234/5678", HI, LO); end
    issue(4'd3, 32'd99, 32'd0, st, n);
    checks++; if (n != 10 || HI !== 32'h1234 || LO !== 32'h5678) begin errors++;
      $display("FAIL div_by_zero: n=%0d HI=%h LO=%h want 10 1234/5678", n, HI, LO); end
    op = 4'd1; D1 = 32'd3; D2 = 32'd4; tick();
    model(4'd1, 32'd3, 32'd4, m_hi, m_lo);
    op = 4'd1; D1 = 32'd7; D2 = 32'd7; #1;
    checks++; if (start !== 1'b0) begin errors++;
      $display("FAIL start_while_busy: got %b want 0", start); end
    tick();
    op = 4'd7; D1 = 32'hDEAD; tick();
    op = 4'd0;
    wait_idle(n);
    checks++; if (n + 2 != 5 || HI !== m_hi || LO !== 32'd12) begin errors++;
      $display("FAIL busy_reject: busy=%0d HI=%h LO=%h want 5 0/c", n + 2, HI, LO); end
  endtask

  task automatic test_reset_mid;
    logic st; int n;
    op = 4'd4; D1 = 32'd100; D2 = 32'd3; tick();
    op = 4'd0;
    tick(); tick(); tick();
    reset = 1'b0; #1;
    m_hi = 32'd0; m_lo = 32'd0;
    checks++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin errors++;
      $display("FAIL reset_mid: busy=%b HI=%h LO=%h want 0 0/0", busy, HI, LO); end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    checks++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin errors++;
      $display("FAIL reset_discard: busy=%b HI=%h LO=%h want 0 0/0", busy, HI, LO); end
    issue(4'd1, 32'd3, 32'd4, st, n);
    checks++; if (n != 5 || LO !== 32'd12 || HI !== 32'd0) begin errors++;
      $display("FAIL post_reset_mult: n=%0d HI=%h LO=%h want 5 0/c", n, HI, LO); end
  endtask

  task automatic test_back_to_back;
    logic st; int n;
    issue(4'd1, 32'd2, 32'd3, st, n);
    checks++; if (LO !== 32'd6) begin errors++; $display("FAIL b2b_first: LO=%h want 6", LO); end
    issue(4'd1, 32'd5, 32'd5, st, n);
    checks++; if (st !== 1'b1 || n != 5 || LO !== 32'd25) begin errors++;
      $display("FAIL b2b_second: start=%b n=%0d LO=%h want 1 5 19", st, n, LO); end
  endtask

  task automatic test_random;
    logic st; int n, want;
    logic [3:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 12));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      if (o >= 4'd1 && o <= 4'd4) begin
        want = (o <= 4'd2) ? 5 : 10;
        issue(o, a, b, st, n);
        checks++; if (st !== 1'b1 || n != want || HI !== m_hi || LO !== m_lo) begin errors++;
          $display("FAIL rand_md op=%0d a=%h b=%h: st=%b n=%0d HI=%h LO=%h want n=%0d %h/%h",
                   o, a, b, st, n, HI, LO, want, m_hi, m_lo); end
      end else begin
        op = o; D1 = a; D2 = b; #1;
        checks++;
        if (XALUOut !== ((o == 4'd5) ? m_hi : (o == 4'd6) ? m_lo : 32'd0) || start !== 1'b0) begin
          errors++;
          $display("FAIL rand_comb op=%0d: XALUOut=%h start=%b", o, XALUOut, start); end
        model(o, a, b, m_hi, m_lo);
        tick();
        op = 4'd0;
        checks++; if (HI !== m_hi || LO !== m_lo) begin errors++;
          $display("FAIL rand_state op=%0d: HI=%h LO=%h want %h/%h", o, HI, LO, m_hi, m_lo); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_divzero_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
